local_mem_sdp: RTL and testbench
================================

# local_mem_sdp

Parametrised simple-dual-port local memory for the AXI Stream coprocessor datapath, the successor to the single-port coprocessor RAM. One write port and one read port operate in the same cycle. It adds selectable read-during-write collision behaviour, an optional output register, a `read_valid` strobe, and a hardware clear engine that zeroes the array without processor involvement. It sits between the stream-input FSM, which writes, and the compute FSM, which reads.

## Interface
- `width`, 8: bits per location.
- `depth_bits`, 2: address bits; the array has 2^depth_bits locations.
- `out_reg`, 0: 0 gives read latency 1; 1 adds an output register for latency 2.
- `collision`, 0: same-address read/write in one cycle. 0 returns old data; 1 returns new data (write-first bypass).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `write_en` in 1: write strobe.
- `write_address` in depth_bits: write location.
- `write_data_in` in width: write data.
- `read_en` in 1: read strobe.
- `read_address` in depth_bits: read location.
- `read_data_out` out width: read data. Holds its value when no read completes.
- `read_valid` out 1: high for one cycle when `read_data_out` carries a newly completed read.
- `clear_start` in 1: one-cycle request to zero the whole array.
- `clear_busy` out 1: high while the clear sweep is running.
- `clear_done` out 1: one-cycle pulse after the last location is zeroed.

## Operation
- Reset values: `read_data_out` = 0, `read_valid` = 0, `clear_busy` = 0, `clear_done` = 0, FSM in IDLE, sweep counter = 0. Array contents are not reset.
- A read and a write to different addresses in the same cycle both complete. Unlike the single-port predecessor, the write does not block the read.
- Same-address read and write in one cycle:
  - `collision`=0: the read returns the pre-write content.
  - `collision`=1: the read returns `write_data_in`.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE→CLEAR on `clear_start`.
  - In CLEAR, one location per cycle is written with 0, at addresses 0 to 2^depth_bits−1 in ascending order.
  - CLEAR→DONE after address 2^depth_bits−1 is written.
  - DONE→IDLE unconditionally, with `clear_done` high during DONE.
- During CLEAR and DONE:
  - External `write_en` and `read_en` are ignored and not queued.
  - `clear_start` is ignored.
  - Reads already in the pipeline complete normally.
- `clear_start` arriving together with `write_en`/`read_en` in IDLE: the external access completes, then the clear starts on the next cycle.
- `reset` asserted during CLEAR: FSM returns to IDLE immediately, `clear_busy` drops, and no `clear_done` is issued. Array contents are then undefined and software must reissue the clear.
- Addresses wrap naturally at 2^depth_bits; no out-of-range check.

## Timing
- `out_reg`=0: data and `read_valid` appear on the edge after the `read_en` edge (latency 1).
- `out_reg`=1: they appear one edge later (latency 2). Back-to-back reads give one result per cycle.
- A write is visible to reads issued on the following cycle.
- `clear_busy` rises on the edge that samples `clear_start` and stays high for exactly 2^depth_bits cycles.
- `clear_done` follows as a one-cycle pulse. The total from `clear_start` to IDLE is 2^depth_bits + 1 cycles.
- The array must infer block RAM: no reset and no read enable on the array itself. Reset applies only to the output/valid registers and the FSM.

## Structure
- Shared package `mem_pkg` holds:
  - collision mode constants `COLL_READ_FIRST`=0 and `COLL_WRITE_FIRST`=1;
  - FSM state encoding IDLE/CLEAR/DONE.
- Sub-module `sdp_ram_core` contains the bare inferred array with one write and one read port, in read-first mode.
- The top-level `local_mem_sdp` contains the write mux (external vs. clear engine), collision bypass, output register, valid pipeline and clear FSM.

## Test plan
- width=8, depth_bits=4. Write 0xA5 at address 3, read address 3 the next cycle: 0xA5 with `read_valid` after 1 cycle (`out_reg`=0) or after 2 cycles (`out_reg`=1).
- Same-cycle write 0x3C to address 5 (old content 0x11) and read of address 5: `collision`=0 returns 0x11; `collision`=1 returns 0x3C.
- Fill all 16 locations with their index, pulse `clear_start`:
  - `clear_busy` is high for 16 cycles, then `clear_done` pulses for 1 cycle;
  - reading all addresses then returns 0;
  - writes issued during busy have no effect.
- Back-to-back reads of addresses 0..15 with `out_reg`=1: 16 consecutive `read_valid` cycles with the correct data order.
- Assert `reset` at sweep cycle 7: all outputs go to 0 asynchronously, and there is no `clear_done`. A new `clear_start` then completes a full 16-cycle sweep.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the coprocessor local memories: read-during-write
// collision modes and the clear-engine state encoding.
package mem_pkg;

   // Same-address read/write in one cycle: old data or new data
   localparam int COLL_READ_FIRST  = 0;
   localparam int COLL_WRITE_FIRST = 1;

   // Clear engine states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/sdp_ram_core.sv
// Bare simple-dual-port array: one write port, one read port, read-first.
// Kept free of reset and read enable so synthesis maps it onto block RAM.
module sdp_ram_core #(
   parameter int width      = 8,
   parameter int depth_bits = 2
) (
   input  logic                  clk,
   input  logic                  write_en,
   input  logic [depth_bits-1:0] write_address,
   input  logic [width-1:0]      write_data_in,
   input  logic [depth_bits-1:0] read_address,
   output logic [width-1:0]      read_data_out
);

   logic [width-1:0] mem [2**depth_bits];

   // Synchronous write and registered read; the read sees pre-write content
   // NOTE: the array has no reset on purpose -- a reset would turn it into flops.
   always_ff @(posedge clk) begin
      if (write_en) begin
         mem[write_address] <= write_data_in;
      end
      read_data_out <= mem[read_address];
   end

endmodule

// File: rtl/local_mem_sdp.sv
// Simple-dual-port local memory for the stream coprocessor: selectable
// collision behaviour, optional output register, read_valid strobe, and a
// clear engine that zeroes the array one location per cycle.
module local_mem_sdp
   import mem_pkg::*;
#(
   parameter int width      = 8,
   parameter int depth_bits = 2,
   parameter int out_reg    = 0,
   parameter int collision  = COLL_READ_FIRST
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write_en,
   input  logic [depth_bits-1:0] write_address,
   input  logic [width-1:0]      write_data_in,
   input  logic                  read_en,
   input  logic [depth_bits-1:0] read_address,
   output logic [width-1:0]      read_data_out,
   output logic                  read_valid,
   input  logic                  clear_start,
   output logic                  clear_busy,
   output logic                  clear_done
);

   localparam logic [depth_bits-1:0] last_address = '1;

   logic [1:0]            state;
   logic [depth_bits-1:0] sweep_count;
   logic                  idle;
   logic                  sweeping;

   logic                  ram_we;
   logic [depth_bits-1:0] ram_wa;
   logic [width-1:0]      ram_wd;
   logic [width-1:0]      ram_q;

   logic                  read_accept;
   logic                  bypass_hit;
   logic                  valid1;
   logic                  bypass1;
   logic [width-1:0]      bypass_data;
   logic [width-1:0]      read1_data;

   assign idle     = (state == ST_IDLE);
   assign sweeping = (state == ST_CLEAR);

   // External accesses are only honoured in IDLE; the sweep owns the write port
   assign ram_we = sweeping | (write_en & idle);
   assign ram_wa = sweeping ? sweep_count : write_address;
   assign ram_wd = sweeping ? '0 : write_data_in;

   assign read_accept = read_en & idle;
   assign bypass_hit  = (collision == COLL_WRITE_FIRST) && read_accept && write_en &&
                        (write_address == read_address);

   sdp_ram_core #(
      .width      (width),
      .depth_bits (depth_bits)
   ) u_core (
      .clk           (clk),
      .write_en      (ram_we),
      .write_address (ram_wa),
      .write_data_in (ram_wd),
      .read_address  (read_address),
      .read_data_out (ram_q)
   );

   // First read stage: valid strobe and write-first bypass capture
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid1      <= 1'b0;
         bypass1     <= 1'b0;
         bypass_data <= '0;
      end else begin
         valid1  <= read_accept;
         bypass1 <= bypass_hit;
         if (bypass_hit) begin
            bypass_data <= write_data_in;
         end
      end
   end

   assign read1_data = bypass1 ? bypass_data : ram_q;

   generate
      if (out_reg != 0) begin : g_out_reg
         logic             valid2;
         logic [width-1:0] data2;

         // Output register: captures only completed reads, otherwise holds
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               valid2 <= 1'b0;
               data2  <= '0;
            end else begin
               valid2 <= valid1;
               if (valid1) begin
                  data2 <= read1_data;
               end
            end
         end

         assign read_data_out = data2;
         assign read_valid    = valid2;
      end else begin : g_no_out_reg
         logic [width-1:0] held;

         // Remember the last completed read so the output holds between reads
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               held <= '0;
            end else if (valid1) begin
               held <= read1_data;
            end
         end

         assign read_data_out = valid1 ? read1_data : held;
         assign read_valid    = valid1;
      end
   endgenerate

   // Clear engine: ascending sweep of every location, then a one-cycle DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         sweep_count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               sweep_count <= '0;
               if (clear_start) begin
                  state <= ST_CLEAR;
               end
            end
            ST_CLEAR: begin
               sweep_count <= sweep_count + 1'b1;
               if (sweep_count == last_address) begin
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign clear_busy = sweeping;
   assign clear_done = (state == ST_DONE);

endmodule

// File: tb/tb_local_mem_sdp.sv
// Self-checking bench for local_mem_sdp: two instances (latency 1 read-first,
// latency 2 write-first) driven in lockstep, checked through a scoreboard.
module tb_local_mem_sdp;
   import mem_pkg::*;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       write_en = 1'b0;
   logic [3:0] write_address = '0;
   logic [7:0] write_data_in = '0;
   logic       read_en = 1'b0;
   logic [3:0] read_address = '0;
   logic       clear_start = 1'b0;

   logic [7:0] a_data, b_data;
   logic       a_valid, b_valid, a_busy, b_busy, a_done, b_done;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   b_valid_cnt = 0;
   logic [7:0] model [16];
   exp_t q_a[$];
   exp_t q_b[$];
   exp_t e_a, e_b;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   local_mem_sdp #(.width(8), .depth_bits(4), .out_reg(0), .collision(COLL_READ_FIRST)) dut_a (
      .clk(clk), .reset(reset),
      .write_en(write_en), .write_address(write_address), .write_data_in(write_data_in),
      .read_en(read_en), .read_address(read_address),
      .read_data_out(a_data), .read_valid(a_valid),
      .clear_start(clear_start), .clear_busy(a_busy), .clear_done(a_done)
   );

   local_mem_sdp #(.width(8), .depth_bits(4), .out_reg(1), .collision(COLL_WRITE_FIRST)) dut_b (
      .clk(clk), .reset(reset),
      .write_en(write_en), .write_address(write_address), .write_data_in(write_data_in),
      .read_en(read_en), .read_address(read_address),
      .read_data_out(b_data), .read_valid(b_valid),
      .clear_start(clear_start), .clear_busy(b_busy), .clear_done(b_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard drain: every read_valid must match the oldest pending read
   always @(negedge clk) begin
      if (a_valid) begin
         if (q_a.size() == 0) begin
            check("a_spurious_valid", 1, 0);
         end else begin
            e_a = q_a.pop_front();
            check("a_data", a_data, e_a.data);
            check("a_latency", cyc, e_a.due);
         end
      end
      if (b_valid) begin
         b_valid_cnt++;
         if (q_b.size() == 0) begin
            check("b_spurious_valid", 1, 0);
         end else begin
            e_b = q_b.pop_front();
            check("b_data", b_data, e_b.data);
            check("b_latency", cyc, e_b.due);
         end
      end
   end

   // One cycle of external access in IDLE; called and returns at a falling edge
   task automatic access(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                         input logic re, input logic [3:0] ra);
      write_en      = we;
      write_address = wa;
      write_data_in = wd;
      read_en       = re;
      read_address  = ra;
      clear_start   = 1'b0;
      if (re) begin
         q_a.push_back('{model[ra], cyc + 1});
         q_b.push_back('{(we && wa == ra) ? wd : model[ra], cyc + 2});
      end
      if (we) model[wa] = wd;
      @(negedge clk);
      write_en = 1'b0;
      read_en  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Full clear sweep with busy/done accounting; optionally hammers the ports
   task automatic sweep(input bit junk);
      int a_busy_cnt, b_busy_cnt, a_done_cnt, b_done_cnt, a_done_pos, first_busy;
      a_busy_cnt = 0; b_busy_cnt = 0; a_done_cnt = 0; b_done_cnt = 0;
      a_done_pos = -1; first_busy = 0;
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (k == 0) first_busy = int'(a_busy);
         if (a_busy) a_busy_cnt++;
         if (b_busy) b_busy_cnt++;
         if (a_done) begin a_done_cnt++; a_done_pos = k; end
         if (b_done) b_done_cnt++;
         if (junk && k < 16) begin
            write_en      = 1'b1;
            write_address = 4'd2;
            write_data_in = 8'hFF;
            read_en       = 1'b1;
            read_address  = 4'd2;
            clear_start   = (k == 3);
         end else begin
            write_en    = 1'b0;
            read_en     = 1'b0;
            clear_start = 1'b0;
         end
         @(negedge clk);
      end
      write_en = 1'b0; read_en = 1'b0; clear_start = 1'b0;
      check("sweep_busy_first", first_busy, 1);
      check("sweep_busy_cycles_a", a_busy_cnt, 16);
      check("sweep_busy_cycles_b", b_busy_cnt, 16);
      check("sweep_done_pulses_a", a_done_cnt, 1);
      check("sweep_done_pulses_b", b_done_cnt, 1);
      check("sweep_done_position", a_done_pos, 16);
      for (int i = 0; i < 16; i++) model[i] = 8'h00;
   endtask

   initial begin
      int cnt0, done_seen;
      for (int i = 0; i < 16; i++) model[i] = 8'h00;

      // Reset values
      idle(2);
      check("rst_a_data", a_data, 0);
      check("rst_a_valid", a_valid, 0);
      check("rst_a_busy", a_busy, 0);
      check("rst_a_done", a_done, 0);
      check("rst_b_data", b_data, 0);
      check("rst_b_valid", b_valid, 0);
      reset = 1'b0;
      idle(1);

      // Write then read next cycle, then the output must hold
      access(1'b1, 4'd3, 8'hA5, 1'b0, 4'd0);
      access(1'b0, 4'd0, 8'h00, 1'b1, 4'd3);
      idle(4);
      check("a_hold", a_data, 8'hA5);
      check("b_hold", b_data, 8'hA5);

      // Same-address collision: read-first vs write-first
      access(1'b1, 4'd5, 8'h11, 1'b0, 4'd0);
      access(1'b1, 4'd5, 8'h3C, 1'b1, 4'd5);
      idle(3);

      // Different-address read and write in one cycle
      access(1'b1, 4'd6, 8'h77, 1'b1, 4'd3);
      idle(3);

      // Fill with index, then back-to-back reads of every address
      for (int i = 0; i < 16; i++) access(1'b1, 4'(i), 8'(i), 1'b0, 4'd0);
      cnt0 = b_valid_cnt;
      for (int i = 0; i < 16; i++) access(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
      idle(3);
      check("b_b2b_count", b_valid_cnt - cnt0, 16);
      check("a_hold_last", a_data, 8'h0F);

      // Clear with ignored port traffic, then everything reads zero
      sweep(1'b1);
      for (int i = 0; i < 16; i++) access(1'b0, 4'd0, 8'h00, 1'b1, 4'(i));
      idle(3);

      // Reset in the middle of a sweep
      for (int i = 0; i < 16; i++) access(1'b1, 4'(i), 8'(i), 1'b0, 4'd0);
      access(1'b0, 4'd0, 8'h00, 1'b1, 4'd9);
      idle(3);
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      idle(6);
      check("mid_busy_before", a_busy, 1);
      check("mid_data_before", a_data, 8'h09);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_a_data", a_data, 0);
      check("mid_rst_b_data", b_data, 0);
      check("mid_rst_a_busy", a_busy, 0);
      check("mid_rst_b_busy", b_busy, 0);
      check("mid_rst_a_valid", a_valid, 0);
      check("mid_rst_done", a_done | b_done, 0);
      @(negedge clk);
      reset = 1'b0;
      done_seen = 0;
      for (int k = 0; k < 20; k++) begin
         if (a_done || b_done || a_busy) done_seen++;
         @(negedge clk);
      end
      check("mid_rst_no_done", done_seen, 0);

      // A fresh clear completes a full sweep
      sweep(1'b0);
      access(1'b0, 4'd0, 8'h00, 1'b1, 4'd0);
      access(1'b0, 4'd0, 8'h00, 1'b1, 4'd7);
      access(1'b0, 4'd0, 8'h00, 1'b1, 4'd15);
      idle(4);

      check("a_queue_empty", q_a.size(), 0);
      check("b_queue_empty", q_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
